gpu_pixel_write_buffer: RTL and testbench
=========================================

Name: gpu_pixel_write_buffer

Overview:
- Write-back stage directly downstream of the texture/CLUT pipe control stage (stage C2 output).
- Per valid pixel: texture modulation by vertex colour, optional dithering, mask-bit generation, transparent-texel discard.
- Coalesces surviving pixels into a 16-pixel (32-byte) VRAM line buffer with a per-pixel write mask, and flushes full or abandoned lines to the memory arbiter over a req/ack handshake.
- Asserts a pause back into the pipe whenever the current pixel cannot be accepted.

Parameters:
- LINE_PIX, 16, pixels per line buffer (fixed by the 32-byte VRAM burst; other values unsupported).

Ports:
- clk  in  1  clock
- i_nrst  in  1  synchronous active-low reset
- GPU_TEX_DISABLE  in  1  primitive untextured
- GPU_REG_RawTexture  in  1  textured, no modulation
- GPU_REG_ForcePixel15MaskSet  in  1  force bit15 = 1
- GPU_REG_DitherOn  in  1  dither enable (used only with GPU_DITHER_EN)
- iValidPixel  in  1  pixel present from C2
- iScrX  in  10  screen X
- iScrY  in  9  screen Y
- iTexel  in  16  texel/CLUT colour, BGR555 + bit15
- iTransparent  in  1  texel all-zero and textured
- iR, iG, iB  in  9 each  vertex colour, 0..511
- iNewBGCacheLine  in  2  non-zero = primitive boundary, flush before next pixel
- iFlush  in  1  end-of-command flush request (level)
- oPause  out  1  stall upstream pipe
- oResetLineFlag  out  1  1-cycle pulse: iNewBGCacheLine consumed
- oWriteReq  out  1  line write request
- oWriteAdr  out  15  {Y[8:0], X[9:4]}
- oWriteData  out  256  pixel i at bits [16i+15:16i]
- oWriteMask  out  16  pixel i valid
- iWriteAck  in  1  1-cycle acceptance of request
- oIdle  out  1  no dirty line, FSM idle

Behaviour:
- Reset (i_nrst=0 at clk edge): state IDLE; mask = 0; tag = 0; data = 0; oWriteReq = 0; oResetLineFlag = 0; oPause = 0; oIdle = 1. A reset during FLUSH abandons the request; the arbiter tolerates a dropped req.
- Colour per channel c (all combinational):
  - GPU_TEX_DISABLE: c8 = min(iC, 255).
  - RawTexture: c8 = tex5 << 3.
  - Otherwise: c8 = min((tex5 × iC) >> 4, 255), using a 14-bit product (tex5 = 31, iC = 128 gives 248).
  - c5 = c8 >> 3.
- Mask bit: textured → iTexel[15] | Force; untextured → Force.
- Discard: textured & iTransparent → pixel consumed, no buffer write.
- States:
  - IDLE: accepts pixels.
  - FLUSH: oWriteReq = 1; oWriteAdr/Data/Mask stable until iWriteAck.
- dirty = (mask != 0). hit = pixel line address == tag.
- needFlush = dirty & ((iValidPixel & !hit & !discard) | (iNewBGCacheLine != 0) | iFlush).
- oPause = (state == FLUSH) | needFlush. Combinational from registered inputs only.
- IDLE & needFlush → FLUSH next cycle; no buffer write this cycle.
- IDLE & !needFlush & iValidPixel & !discard:
  - if !dirty, tag ← pixel line address;
  - data[X[3:0]] ← pixel; mask[X[3:0]] ← 1;
  - same-pixel rewrite overwrites (last wins).
- FLUSH & iWriteAck → mask ← 0, IDLE. Upstream stays paused that cycle; the held pixel is accepted the cycle after.
- iNewBGCacheLine != 0 with !dirty:
  - oResetLineFlag pulses in the same cycle;
  - the pixel (if valid) is accepted that cycle;
  - no flush.
- iNewBGCacheLine != 0 with dirty: flush first; oResetLineFlag pulses in the cycle IDLE resumes.
- Full line (all 16 mask bits set) is not flushed eagerly; it flushes on the next miss, boundary, or iFlush.
- Latency: accepted pixel appears in oWriteData at the next FLUSH entry (≥ 1 cycle).
- oIdle = (state == IDLE) & !dirty.

Optional Feature:
- GPU_DITHER_EN defined:
  - when GPU_REG_DitherOn & !RawTexture, add D[Y[1:0]][X[1:0]] to c8 before clamp to 0..255, then >>3;
  - matrix rows: {-4,0,-3,1}, {2,-2,3,-1}, {-3,1,-4,0}, {3,-1,2,-2}.
- Undefined: GPU_REG_DitherOn ignored; no adder logic.

Test Plan:
- Untextured, iR=iG=iB=255, Force=0, pixels X=0..15 at Y=5, then iFlush → one write, oWriteAdr=0x0140, mask=0xFFFF, every pixel 0x7FFF, oIdle=1 after ack.
- Textured, iTexel=0x7FFF, iR=128 → c5=31; iR=64 → 15 (0x3DEF at equal channels); iTexel bit15=1 → pixel bit15=1.
- iTransparent=1 textured pixel into empty buffer → no write, oPause=0, mask stays 0.
- Pixel X=3,Y=0, then X=20,Y=0 → oPause for flush; write of adr 0 with mask 0x0008; ack held off 4 cycles keeps req/data stable; X=20 accepted cycle after ack, mask=0x0010.
- iNewBGCacheLine=2'b01 with dirty line → flush, then oResetLineFlag 1-cycle pulse; with empty buffer → pulse same cycle, no write.
- Reset asserted during FLUSH before ack → next cycle oWriteReq=0, oIdle=1, mask=0.

Source files
------------

// File: rtl/gpu_pixel_write_buffer.sv
// Pixel write-back: colour shading, mask bit, transparent discard, and 16-pixel VRAM line coalescing.
// Optional ordered dithering is compiled in when GPU_DITHER_EN is defined.
module gpu_pixel_write_buffer #(
  parameter int LINE_PIX = 16
) (
  input  logic                     clk,
  input  logic                     i_nrst,
  input  logic                     GPU_TEX_DISABLE,
  input  logic                     GPU_REG_RawTexture,
  input  logic                     GPU_REG_ForcePixel15MaskSet,
  input  logic                     GPU_REG_DitherOn,
  input  logic                     iValidPixel,
  input  logic [9:0]               iScrX,
  input  logic [8:0]               iScrY,
  input  logic [15:0]              iTexel,
  input  logic                     iTransparent,
  input  logic [8:0]               iR,
  input  logic [8:0]               iG,
  input  logic [8:0]               iB,
  input  logic [1:0]               iNewBGCacheLine,
  input  logic                     iFlush,
  output logic                     oPause,
  output logic                     oResetLineFlag,
  output logic                     oWriteReq,
  output logic [14:0]              oWriteAdr,
  output logic [LINE_PIX*16-1:0]   oWriteData,
  output logic [LINE_PIX-1:0]      oWriteMask,
  input  logic                     iWriteAck,
  output logic                     oIdle
);

  typedef enum logic {IDLE, FLUSH} stateT;

  stateT                stateReg, stateNext;
  logic [LINE_PIX-1:0]  maskReg, maskNext;
  logic [14:0]          tagReg, tagNext;
  logic                 pixWrite;

  logic                 textured;
  logic                 discard;
  logic                 maskBit;
  logic [2:0][4:0]      chan5;
  logic [15:0]          pixel;
  logic [26:0]          vtxColor;
  logic [14:0]          pixAdr;
  logic                 dirty;
  logic                 hit;
  logic                 newLine;
  logic                 needFlush;

  assign textured = !GPU_TEX_DISABLE;
  assign discard  = textured & iTransparent;
  assign maskBit  = (textured & iTexel[15]) | GPU_REG_ForcePixel15MaskSet;
  assign vtxColor = {iB, iG, iR};
  assign pixel    = {maskBit, chan5};

`ifdef GPU_DITHER_EN
  logic signed [3:0] ditherVal;
  logic              ditherActive;

  assign ditherActive = GPU_REG_DitherOn & !GPU_REG_RawTexture;

  // 4x4 ordered-dither offsets indexed by {Y[1:0], X[1:0]}
  always_comb begin
    ditherVal = 4'sd0;
    case ({iScrY[1:0], iScrX[1:0]})
      4'h0: ditherVal = -4'sd4;  4'h1: ditherVal =  4'sd0;
      4'h2: ditherVal = -4'sd3;  4'h3: ditherVal =  4'sd1;
      4'h4: ditherVal =  4'sd2;  4'h5: ditherVal = -4'sd2;
      4'h6: ditherVal =  4'sd3;  4'h7: ditherVal = -4'sd1;
      4'h8: ditherVal = -4'sd3;  4'h9: ditherVal =  4'sd1;
      4'hA: ditherVal = -4'sd4;  4'hB: ditherVal =  4'sd0;
      4'hC: ditherVal =  4'sd3;  4'hD: ditherVal = -4'sd1;
      4'hE: ditherVal =  4'sd2;  default: ditherVal = -4'sd2;
    endcase
  end
`else
  logic unusedDitherOn;
  assign unusedDitherOn = GPU_REG_DitherOn;
`endif

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : genChan
    logic [4:0]  tex5;
    logic [8:0]  vtx;
    logic [13:0] prod;
    logic [9:0]  base;
    logic [7:0]  c8;

    assign tex5 = iTexel[5*gi +: 5];
    assign vtx  = vtxColor[9*gi +: 9];
    assign prod = 14'(tex5) * 14'(vtx);

    always_comb begin
      base = 10'(prod >> 4);
      if (GPU_TEX_DISABLE)
        base = {1'b0, vtx};
      else if (GPU_REG_RawTexture)
        base = {2'b00, tex5, 3'b000};
    end

`ifdef GPU_DITHER_EN
    logic [7:0]         preClamp;
    logic signed [11:0] dSum;
    logic [11:0]        dExt;

    assign preClamp = (base > 10'd255) ? 8'd255 : base[7:0];
    assign dExt     = ditherActive ? {{8{ditherVal[3]}}, ditherVal} : 12'd0;
    assign dSum     = $signed({4'b0000, preClamp}) + $signed(dExt);
    assign c8       = (dSum < 0) ? 8'd0 : (dSum > 12'sd255) ? 8'd255 : dSum[7:0];
`else
    assign c8 = (base > 10'd255) ? 8'd255 : base[7:0];
`endif

    assign chan5[gi] = c8[7:3];
  end

  assign pixAdr    = {iScrY, iScrX[9:4]};
  assign dirty     = |maskReg;
  assign hit       = (pixAdr == tagReg);
  assign newLine   = |iNewBGCacheLine;
  assign needFlush = dirty & ((iValidPixel & !hit & !discard) | newLine | iFlush);

  always_ff @(posedge clk) begin
    if (!i_nrst) begin
      stateReg <= IDLE;
      maskReg  <= '0;
      tagReg   <= '0;
    end else begin
      stateReg <= stateNext;
      maskReg  <= maskNext;
      tagReg   <= tagNext;
    end
  end

  always_comb begin
    stateNext      = stateReg;
    maskNext       = maskReg;
    tagNext        = tagReg;
    pixWrite       = 1'b0;
    oWriteReq      = 1'b0;
    oPause         = 1'b0;
    oResetLineFlag = 1'b0;
    case (stateReg)
      IDLE: begin
        oPause = needFlush;
        if (needFlush) begin
          stateNext = FLUSH;
        end else begin
          // Boundary with a clean buffer is consumed immediately alongside the pixel
          oResetLineFlag = newLine;
          if (iValidPixel && !discard) begin
            pixWrite               = 1'b1;
            maskNext[iScrX[3:0]]   = 1'b1;
            if (!dirty) tagNext    = pixAdr;
          end
        end
      end
      FLUSH: begin
        oWriteReq = 1'b1;
        oPause    = 1'b1;
        if (iWriteAck) begin
          maskNext  = '0;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  for (gi = 0; gi < LINE_PIX; gi++) begin : genLine
    logic [15:0] pixReg;

    always_ff @(posedge clk) begin
      if (!i_nrst)
        pixReg <= '0;
      else if (pixWrite && (iScrX[3:0] == 4'(gi)))
        pixReg <= pixel;
    end

    assign oWriteData[16*gi +: 16] = pixReg;
  end

  assign oWriteAdr  = tagReg;
  assign oWriteMask = maskReg;
  assign oIdle      = (stateReg == IDLE) & !dirty;

endmodule

// File: tb/tb_gpu_pixel_write_buffer.sv
// Directed bench for gpu_pixel_write_buffer: shading, coalescing, flush handshake, boundaries, reset.
module tb_gpu_pixel_write_buffer;

  logic         clk = 1'b0;
  logic         i_nrst;
  logic         GPU_TEX_DISABLE, GPU_REG_RawTexture, GPU_REG_ForcePixel15MaskSet, GPU_REG_DitherOn;
  logic         iValidPixel;
  logic [9:0]   iScrX;
  logic [8:0]   iScrY;
  logic [15:0]  iTexel;
  logic         iTransparent;
  logic [8:0]   iR, iG, iB;
  logic [1:0]   iNewBGCacheLine;
  logic         iFlush;
  logic         oPause, oResetLineFlag, oWriteReq;
  logic [14:0]  oWriteAdr;
  logic [255:0] oWriteData;
  logic [15:0]  oWriteMask;
  logic         iWriteAck;
  logic         oIdle;

  int passCount = 0;
  int totalCount = 0;

  always #5 clk = ~clk;

  gpu_pixel_write_buffer dut (
    .clk(clk), .i_nrst(i_nrst),
    .GPU_TEX_DISABLE(GPU_TEX_DISABLE), .GPU_REG_RawTexture(GPU_REG_RawTexture),
    .GPU_REG_ForcePixel15MaskSet(GPU_REG_ForcePixel15MaskSet), .GPU_REG_DitherOn(GPU_REG_DitherOn),
    .iValidPixel(iValidPixel), .iScrX(iScrX), .iScrY(iScrY), .iTexel(iTexel),
    .iTransparent(iTransparent), .iR(iR), .iG(iG), .iB(iB),
    .iNewBGCacheLine(iNewBGCacheLine), .iFlush(iFlush),
    .oPause(oPause), .oResetLineFlag(oResetLineFlag), .oWriteReq(oWriteReq),
    .oWriteAdr(oWriteAdr), .oWriteData(oWriteData), .oWriteMask(oWriteMask),
    .iWriteAck(iWriteAck), .oIdle(oIdle)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic setPixel(input logic [9:0] x, input logic [8:0] y, input logic [15:0] tex,
                          input logic [8:0] r, input logic [8:0] g, input logic [8:0] b);
    iValidPixel = 1'b1; iScrX = x; iScrY = y; iTexel = tex; iR = r; iG = g; iB = b;
  endtask

  // Flush whatever is buffered with an immediate ack; leaves inputs idle
  task automatic flushNow();
    iValidPixel = 1'b0; iFlush = 1'b1; tick();
    iWriteAck = 1'b1; tick();
    iWriteAck = 1'b0; iFlush = 1'b0;
  endtask

  task automatic test_reset();
    i_nrst = 1'b0; tick(); tick(); settle();
    totalCount++; if (oWriteReq !== 1'b0) $display("FAIL reset_req got=%b exp=0", oWriteReq); else passCount++;
    totalCount++; if (oPause !== 1'b0) $display("FAIL reset_pause got=%b exp=0", oPause); else passCount++;
    totalCount++; if (oIdle !== 1'b1) $display("FAIL reset_idle got=%b exp=1", oIdle); else passCount++;
    totalCount++; if (oWriteMask !== 16'h0) $display("FAIL reset_mask got=%h exp=0000", oWriteMask); else passCount++;
    totalCount++; if (oResetLineFlag !== 1'b0) $display("FAIL reset_flag got=%b exp=0", oResetLineFlag); else passCount++;
    totalCount++; if (oWriteData !== 256'h0) $display("FAIL reset_data got=%h exp=0", oWriteData); else passCount++;
    i_nrst = 1'b1; tick();
    $display("reset: done");
  endtask

  task automatic test_untextured_line();
    int pauseErr = 0;
    int dataErr = 0;
    GPU_TEX_DISABLE = 1'b1;
    for (int x = 0; x < 16; x++) begin
      setPixel(10'(x), 9'd5, 16'h0000, 9'd255, 9'd255, 9'd255);
      settle(); if (oPause !== 1'b0) pauseErr++;
      tick();
    end
    totalCount++; if (pauseErr != 0) $display("FAIL line_nopause got=%0d paused cycles exp=0", pauseErr); else passCount++;
    iValidPixel = 1'b0; iFlush = 1'b1;
    settle();
    totalCount++; if (oPause !== 1'b1) $display("FAIL line_flush_pause got=%b exp=1", oPause); else passCount++;
    tick(); settle();
    totalCount++; if (oWriteReq !== 1'b1) $display("FAIL line_req got=%b exp=1", oWriteReq); else passCount++;
    totalCount++; if (oWriteAdr !== 15'h0140) $display("FAIL line_adr got=%h exp=0140", oWriteAdr); else passCount++;
    totalCount++; if (oWriteMask !== 16'hFFFF) $display("FAIL line_mask got=%h exp=ffff", oWriteMask); else passCount++;
    for (int i = 0; i < 16; i++) if (oWriteData[16*i +: 16] !== 16'h7FFF) dataErr++;
    totalCount++; if (dataErr != 0) $display("FAIL line_data got=%0d bad pixels exp=0 (all 7fff)", dataErr); else passCount++;
    totalCount++; if (oIdle !== 1'b0) $display("FAIL line_busy got=%b exp=0", oIdle); else passCount++;
    iWriteAck = 1'b1; tick();
    iWriteAck = 1'b0; iFlush = 1'b0; settle();
    totalCount++; if (oIdle !== 1'b1) $display("FAIL line_idle_after got=%b exp=1", oIdle); else passCount++;
    totalCount++; if (oWriteReq !== 1'b0) $display("FAIL line_req_drop got=%b exp=0", oWriteReq); else passCount++;
    tick();
    $display("untextured_line: 16 pixels, one write");
  endtask

  task automatic test_modulate();
    logic [15:0] expPix [6];
    // X0: 31*128>>4=248 -> 31; X1: 31*64>>4=124 -> 15; X2: same plus bit15
    // X3: raw 1<<3 -> 1; X4: untextured, force, R clamps; X5: 31*511 clamps to 255
    expPix[0] = 16'h7FFF; expPix[1] = 16'h3DEF; expPix[2] = 16'hBDEF;
    expPix[3] = 16'h0421; expPix[4] = 16'h841F; expPix[5] = 16'h7C1F;
    GPU_TEX_DISABLE = 1'b0;
    setPixel(10'd0, 9'd0, 16'h7FFF, 9'd128, 9'd128, 9'd128); tick();
    setPixel(10'd1, 9'd0, 16'h7FFF, 9'd64, 9'd64, 9'd64); tick();
    setPixel(10'd2, 9'd0, 16'hFFFF, 9'd64, 9'd64, 9'd64); tick();
    GPU_REG_RawTexture = 1'b1;
    setPixel(10'd3, 9'd0, 16'h0421, 9'd7, 9'd300, 9'd9); tick();
    GPU_REG_RawTexture = 1'b0; GPU_TEX_DISABLE = 1'b1; GPU_REG_ForcePixel15MaskSet = 1'b1;
    setPixel(10'd4, 9'd0, 16'h0000, 9'd300, 9'd0, 9'd8); tick();
    GPU_TEX_DISABLE = 1'b0; GPU_REG_ForcePixel15MaskSet = 1'b0;
    setPixel(10'd5, 9'd0, 16'h7FFF, 9'd511, 9'd0, 9'd128); tick();
    iValidPixel = 1'b0; iFlush = 1'b1; tick(); settle();
    totalCount++; if (oWriteMask !== 16'h003F) $display("FAIL mod_mask got=%h exp=003f", oWriteMask); else passCount++;
    totalCount++; if (oWriteAdr !== 15'h0000) $display("FAIL mod_adr got=%h exp=0000", oWriteAdr); else passCount++;
    for (int i = 0; i < 6; i++) begin
      totalCount++;
      if (oWriteData[16*i +: 16] !== expPix[i])
        $display("FAIL mod_pix%0d got=%h exp=%h", i, oWriteData[16*i +: 16], expPix[i]);
      else passCount++;
    end
    iWriteAck = 1'b1; tick();
    iWriteAck = 1'b0; iFlush = 1'b0;
    $display("modulate: 6 pixels shaded");
  endtask

  task automatic test_transparent();
    GPU_TEX_DISABLE = 1'b0; iTransparent = 1'b1;
    setPixel(10'd7, 9'd3, 16'h0000, 9'd100, 9'd100, 9'd100);
    settle();
    totalCount++; if (oPause !== 1'b0) $display("FAIL transp_pause got=%b exp=0", oPause); else passCount++;
    tick(); iValidPixel = 1'b0; iTransparent = 1'b0; settle();
    totalCount++; if (oWriteMask !== 16'h0) $display("FAIL transp_mask got=%h exp=0000", oWriteMask); else passCount++;
    totalCount++; if (oIdle !== 1'b1) $display("FAIL transp_idle got=%b exp=1", oIdle); else passCount++;
    tick();
    $display("transparent: texel discarded");
  endtask

  task automatic test_miss_flush();
    int stableErr = 0;
    GPU_TEX_DISABLE = 1'b1;
    setPixel(10'd3, 9'd0, 16'h0000, 9'd255, 9'd255, 9'd255); tick();
    setPixel(10'd20, 9'd0, 16'h0000, 9'd255, 9'd255, 9'd255); settle();
    totalCount++; if (oPause !== 1'b1) $display("FAIL miss_pause got=%b exp=1", oPause); else passCount++;
    tick();
    for (int c = 0; c < 4; c++) begin
      settle();
      if (oWriteReq !== 1'b1 || oWriteAdr !== 15'h0 || oWriteMask !== 16'h0008 ||
          oWriteData[63:48] !== 16'h7FFF || oPause !== 1'b1) stableErr++;
      tick();
    end
    totalCount++; if (stableErr != 0) $display("FAIL miss_hold got=%0d unstable cycles exp=0", stableErr); else passCount++;
    iWriteAck = 1'b1; settle();
    totalCount++; if (oPause !== 1'b1) $display("FAIL miss_ack_pause got=%b exp=1", oPause); else passCount++;
    tick(); iWriteAck = 1'b0; settle();
    totalCount++; if (oPause !== 1'b0) $display("FAIL miss_resume_pause got=%b exp=0", oPause); else passCount++;
    totalCount++; if (oWriteReq !== 1'b0) $display("FAIL miss_req_drop got=%b exp=0", oWriteReq); else passCount++;
    tick(); iValidPixel = 1'b0; settle();
    totalCount++; if (oWriteMask !== 16'h0010) $display("FAIL miss_newmask got=%h exp=0010", oWriteMask); else passCount++;
    totalCount++; if (oWriteAdr !== 15'h0001) $display("FAIL miss_newadr got=%h exp=0001", oWriteAdr); else passCount++;
    tick(); flushNow();
    $display("miss_flush: held ack, X=20 accepted after");
  endtask

  task automatic test_new_line();
    GPU_TEX_DISABLE = 1'b1;
    setPixel(10'd0, 9'd1, 16'h0000, 9'd8, 9'd8, 9'd8); tick();
    iValidPixel = 1'b0; iNewBGCacheLine = 2'b01; settle();
    totalCount++; if (oPause !== 1'b1 || oResetLineFlag !== 1'b0)
      $display("FAIL nl_dirty_first got=pause%b flag%b exp=pause1 flag0", oPause, oResetLineFlag); else passCount++;
    tick(); settle();
    totalCount++; if (oWriteReq !== 1'b1 || oWriteAdr !== 15'h0040)
      $display("FAIL nl_dirty_write got=req%b adr%h exp=req1 adr0040", oWriteReq, oWriteAdr); else passCount++;
    iWriteAck = 1'b1; tick(); iWriteAck = 1'b0; settle();
    totalCount++; if (oResetLineFlag !== 1'b1 || oPause !== 1'b0)
      $display("FAIL nl_dirty_pulse got=flag%b pause%b exp=flag1 pause0", oResetLineFlag, oPause); else passCount++;
    tick(); iNewBGCacheLine = 2'b00; settle();
    totalCount++; if (oResetLineFlag !== 1'b0) $display("FAIL nl_pulse_width got=%b exp=0", oResetLineFlag); else passCount++;
    tick();
    iNewBGCacheLine = 2'b01; setPixel(10'd5, 9'd2, 16'h0000, 9'd255, 9'd0, 9'd0); settle();
    totalCount++; if (oResetLineFlag !== 1'b1 || oPause !== 1'b0)
      $display("FAIL nl_clean_pulse got=flag%b pause%b exp=flag1 pause0", oResetLineFlag, oPause); else passCount++;
    tick(); iNewBGCacheLine = 2'b00; iValidPixel = 1'b0; settle();
    totalCount++; if (oWriteReq !== 1'b0 || oWriteMask !== 16'h0020 || oWriteAdr !== 15'h0080)
      $display("FAIL nl_clean_accept got=req%b mask%h adr%h exp=req0 mask0020 adr0080", oWriteReq, oWriteMask, oWriteAdr);
    else passCount++;
    totalCount++; if (oWriteData[95:80] !== 16'h001F) $display("FAIL nl_clean_pix got=%h exp=001f", oWriteData[95:80]); else passCount++;
    tick(); flushNow();
    $display("new_line: dirty and clean boundaries");
  endtask

  task automatic test_reset_in_flush();
    GPU_TEX_DISABLE = 1'b1;
    setPixel(10'd9, 9'd4, 16'h0000, 9'd40, 9'd40, 9'd40); tick();
    iValidPixel = 1'b0; iFlush = 1'b1; tick(); settle();
    totalCount++; if (oWriteReq !== 1'b1) $display("FAIL rf_req got=%b exp=1", oWriteReq); else passCount++;
    tick(); i_nrst = 1'b0; iFlush = 1'b0; tick(); settle();
    totalCount++; if (oWriteReq !== 1'b0 || oIdle !== 1'b1 || oWriteMask !== 16'h0)
      $display("FAIL rf_after got=req%b idle%b mask%h exp=req0 idle1 mask0000", oWriteReq, oIdle, oWriteMask);
    else passCount++;
    i_nrst = 1'b1; tick();
    $display("reset_in_flush: request abandoned");
  endtask

  initial begin
    i_nrst = 1'b0; GPU_TEX_DISABLE = 1'b0; GPU_REG_RawTexture = 1'b0;
    GPU_REG_ForcePixel15MaskSet = 1'b0; GPU_REG_DitherOn = 1'b0;
    iValidPixel = 1'b0; iScrX = '0; iScrY = '0; iTexel = '0; iTransparent = 1'b0;
    iR = '0; iG = '0; iB = '0; iNewBGCacheLine = 2'b00; iFlush = 1'b0; iWriteAck = 1'b0;
    test_reset();
    test_untextured_line();
    test_modulate();
    test_transparent();
    test_miss_flush();
    test_new_line();
    test_reset_in_flush();
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
